cnn_result_tx: RTL
==================

Name: cnn_result_tx

Overview:
- Output stage downstream of the fully-connected layer and the `led` one-hot classification.
- On a `start` pulse it latches the 10 FC scores and the one-hot class, then serialises a fixed 43-byte result packet over a UART 8N1 line (`TxD`).
- It raises `done` for one cycle when the packet has finished.
- It is the transmit half of the CNN top level; the top-level `state` output can be driven directly from this block.

Parameters:
- CLASSIFICATIONS, 10, number of classes / scores.
- FC_RESULT_DEPTH, 30, bit width of each FC score (must be <=32).
- CLKS_PER_BIT, 868, clocks per UART bit (100 MHz / 115200).
- HEADER_BYTE, 8'hA5, first byte of every packet.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse: inputs valid, begin packet.
- led  input  CLASSIFICATIONS  one-hot classification result.
- scores  input  CLASSIFICATIONS*FC_RESULT_DEPTH  flattened FC outputs, unsigned; class i at bits [i*FC_RESULT_DEPTH +: FC_RESULT_DEPTH].
- TxD  output  1  UART serial out, idle high.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after final stop bit.
- state  output  3  current FSM state encoding.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: TxD=1, busy=0, done=0, state=IDLE, byte counter=0, checksum=0. All latched data is cleared.
- States (3-bit): IDLE=0, LATCH=1, SEND=2, GAP=3, DONE=4. Codes 5-7 are unused and return to IDLE.
- IDLE:
  - TxD=1.
  - On start=1 go to LATCH. The cycle in which start is sampled is cycle 0.
- LATCH (cycle 1):
  - Capture scores and led into internal registers. Later input changes have no effect.
  - Compute class index = position of the lowest set bit of led. If led==0, index = 8'hFF.
  - Clear the checksum; set byte counter=0; busy=1.
  - Go to SEND.
- SEND:
  - Hand the current byte to the byte serialiser. The start bit (TxD=0) begins at cycle 2 for byte 0.
  - Each byte takes exactly 10*CLKS_PER_BIT cycles: start bit, 8 data bits LSB first, stop bit (TxD=1).
  - After the stop bit completes go to GAP, or go to DONE if the counter is 42.
- GAP:
  - Exactly 2 clocks of TxD=1, then increment the counter and return to SEND.
- Packet byte order:
  - Byte 0: HEADER_BYTE.
  - Byte 1: class index.
  - Bytes 2..41: score[0]..score[9], each zero-extended to 32 bits and sent big-endian (4 bytes per score).
  - Byte 42: checksum = XOR of bytes 0..41.
- DONE:
  - done=1 for exactly one cycle; busy=0 in the same cycle; go to IDLE.
- start while busy: ignored. No queuing; the current packet is unaffected.
- start in the DONE cycle: ignored. A new packet may start from the first IDLE cycle.
- Reset mid-packet: TxD returns high immediately (asynchronous). The FSM returns to IDLE and no done pulse is produced. The receiver sees a truncated frame, which is acceptable.
- Arithmetic: the bit counter must count 0..CLKS_PER_BIT-1, sized with $clog2. The byte counter is 6 bits.

Decomposition:
- Shared package cnn_pkg holds:
  - CLASSIFICATIONS and FC_RESULT_DEPTH defaults;
  - state encoding localparams (IDLE, LATCH, SEND, GAP, DONE);
  - PACKET_BYTES=43;
  - HEADER_BYTE.
- One sub-module, uart_tx_byte, forms the 8N1 frame.
  - Parameter: CLKS_PER_BIT.
  - Ports: clk, rst, tx_start, tx_data[7:0], tx_line, tx_done.
  - tx_done pulses on the last cycle of the stop bit.
- The packet FSM, byte mux and checksum live in cnn_result_tx.

Test Plan (CLKS_PER_BIT=4; bench-side UART receiver decodes TxD):
- Reset then idle for 100 cycles -> TxD=1, busy=0, done=0, state=0 throughout.
- led=10'b0000001000, score[i]=i*1000, pulse start -> TxD falls at cycle 2; 43 bytes decoded: A5, 03, then 00 00 00 00, 00 00 03 E8, ... 00 00 23 28, then the XOR checksum. done pulses once; total duration = 2+43*40+42*2 cycles.
- led=0, all scores 30'h3FFFFFFF -> byte1=FF, each score decodes as 3F FF FF FF, checksum matches the reference XOR.
- start pulsed again at byte 10 and during the DONE cycle -> packet unchanged, exactly one done pulse; a start one cycle after DONE begins a new packet correctly.
- Scores changed on the cycle after start -> transmitted values equal those present at the LATCH cycle.
- rst asserted mid-byte 20 -> TxD=1 in the same cycle, state=0, no done pulse; a subsequent start sends a full, correct packet.

Source files
------------

// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Constants and types shared by the CNN result transmitter and its byte
// serialiser.
//   CLASSIFICATIONS / FC_RESULT_DEPTH : default FC layer geometry
//   PACKET_BYTES / HEADER_BYTE        : result packet framing
//   tx_state_e                        : packet FSM encoding, also exported on
//                                       the top-level state port
// -----------------------------------------------------------------------------
package cnn_pkg;

  localparam int CLASSIFICATIONS = 10;
  localparam int FC_RESULT_DEPTH = 30;

  // Header, class index, 10 scores x 4 bytes, checksum.
  localparam int PACKET_BYTES = 43;
  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    SEND  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// Serialises one byte as a UART 8N1 frame: start bit, 8 data bits LSB first,
// stop bit, each CLKS_PER_BIT clocks long.
//   clk      : system clock
//   rst      : asynchronous active-high reset, forces the line high
//   tx_start : one-cycle request, accepted only while idle
//   tx_data  : byte to send, sampled with tx_start
//   tx_line  : serial output, idle high; first start-bit cycle follows tx_start
//   tx_done  : high on the last clock of the stop bit
// -----------------------------------------------------------------------------
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_line,
  output logic       tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             active_reg;
  logic [CNT_W-1:0] clk_cnt_reg;
  logic [3:0]       bit_idx_reg;
  // Frame shift register; bit 0 is the line. Refilled with ones as it shifts,
  // so it reads all-ones (idle high) once the stop bit has gone out.
  logic [9:0]       frame_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_reg  <= 1'b0;
      clk_cnt_reg <= '0;
      bit_idx_reg <= '0;
      frame_reg   <= '1;
    end else if (!active_reg) begin
      if (tx_start) begin
        active_reg  <= 1'b1;
        clk_cnt_reg <= '0;
        bit_idx_reg <= '0;
        frame_reg   <= {1'b1, tx_data, 1'b0};
      end
    end else if (clk_cnt_reg == CNT_LAST) begin
      clk_cnt_reg <= '0;
      frame_reg   <= {1'b1, frame_reg[9:1]};
      if (bit_idx_reg == 4'd9) begin
        active_reg  <= 1'b0;
        bit_idx_reg <= '0;
      end else begin
        bit_idx_reg <= bit_idx_reg + 4'd1;
      end
    end else begin
      clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
    end
  end

  assign tx_line = frame_reg[0];
  assign tx_done = active_reg && (clk_cnt_reg == CNT_LAST) && (bit_idx_reg == 4'd9);

endmodule

// File: rtl/cnn_result_tx.sv
// -----------------------------------------------------------------------------
// cnn_result_tx
// Latches the FC scores and one-hot class on start, then sends a 43-byte
// packet over UART 8N1: header, class index, ten big-endian 32-bit scores,
// XOR checksum of the preceding 42 bytes. Consecutive bytes are separated by
// two idle-high clocks.
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   start  : one-cycle request, honoured only in IDLE
//   led    : one-hot classification (lowest set bit wins, none -> 8'hFF)
//   scores : flattened unsigned FC outputs, class i at [i*W +: W]
//   TxD    : UART serial output, idle high
//   busy   : high in LATCH, SEND and GAP
//   done   : one-cycle pulse after the final stop bit
//   state  : current FSM state code
// -----------------------------------------------------------------------------
module cnn_result_tx #(
  parameter int         CLASSIFICATIONS = cnn_pkg::CLASSIFICATIONS,
  parameter int         FC_RESULT_DEPTH = cnn_pkg::FC_RESULT_DEPTH,
  parameter int         CLKS_PER_BIT    = 868,
  parameter logic [7:0] HEADER_BYTE     = cnn_pkg::HEADER_BYTE
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [CLASSIFICATIONS-1:0]                 led,
  input  logic [CLASSIFICATIONS*FC_RESULT_DEPTH-1:0] scores,
  output logic                                       TxD,
  output logic                                       busy,
  output logic                                       done,
  output logic [2:0]                                 state
);

  import cnn_pkg::*;

  localparam int IDX_W = (CLASSIFICATIONS > 1) ? $clog2(CLASSIFICATIONS) : 1;
  localparam logic [5:0] LAST_BYTE = 6'(PACKET_BYTES - 1);

  tx_state_e            state_reg, state_next;
  logic [5:0]           byte_cnt_reg, byte_cnt_next;
  logic                 gap_cnt_reg, gap_cnt_next;
  logic [7:0]           checksum_reg, checksum_next;
  logic [7:0]           class_idx_reg, class_idx_next;
  logic [FC_RESULT_DEPTH-1:0] score_reg [CLASSIFICATIONS];
  logic [FC_RESULT_DEPTH-1:0] score_in  [CLASSIFICATIONS];

  logic       capture;
  logic       tx_start;
  logic [5:0] tx_sel;
  logic [7:0] tx_data;
  logic [7:0] cur_byte;
  logic       tx_done;

  // Unpack the flat score bus into per-class slices.
  genvar gi;
  generate
    for (gi = 0; gi < CLASSIFICATIONS; gi++) begin : g_unpack
      assign score_in[gi] = scores[gi*FC_RESULT_DEPTH +: FC_RESULT_DEPTH];
    end
  endgenerate

  // Lowest set bit of led; scanning downward lets the lowest index win.
  always_comb begin
    class_idx_next = 8'hFF;
    for (int i = CLASSIFICATIONS - 1; i >= 0; i--) begin
      if (led[i]) class_idx_next = 8'(i);
    end
  end

  // Packet byte for a given position, built from the latched data.
  function automatic logic [7:0] packet_byte(input logic [5:0] idx);
    logic [5:0]       rel;
    logic [IDX_W-1:0] k;
    logic [31:0]      word;
    packet_byte = 8'h00;
    rel  = idx - 6'd2;
    k    = IDX_W'(rel[5:2]);
    word = '0;
    if (idx == 6'd0) begin
      packet_byte = HEADER_BYTE;
    end else if (idx == 6'd1) begin
      packet_byte = class_idx_reg;
    end else if (idx == LAST_BYTE) begin
      packet_byte = checksum_reg;
    end else begin
      if (int'(rel[5:2]) < CLASSIFICATIONS) word = 32'(score_reg[k]);
      case (rel[1:0])
        2'd0:    packet_byte = word[31:24];
        2'd1:    packet_byte = word[23:16];
        2'd2:    packet_byte = word[15:8];
        default: packet_byte = word[7:0];
      endcase
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      byte_cnt_reg  <= '0;
      gap_cnt_reg   <= 1'b0;
      checksum_reg  <= '0;
      class_idx_reg <= '0;
      for (int i = 0; i < CLASSIFICATIONS; i++) score_reg[i] <= '0;
    end else begin
      state_reg    <= state_next;
      byte_cnt_reg <= byte_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      checksum_reg <= checksum_next;
      if (capture) begin
        class_idx_reg <= class_idx_next;
        for (int i = 0; i < CLASSIFICATIONS; i++) score_reg[i] <= score_in[i];
      end
    end
  end

  // Each byte is requested one cycle before its start bit, so the request
  // comes from LATCH for byte 0 and from the last GAP cycle for the rest.
  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    checksum_next = checksum_reg;
    capture       = 1'b0;
    tx_start      = 1'b0;
    tx_sel        = 6'd0;
    busy          = 1'b0;
    done          = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) state_next = LATCH;
      end
      LATCH: begin
        busy          = 1'b1;
        capture       = 1'b1;
        checksum_next = '0;
        byte_cnt_next = '0;
        gap_cnt_next  = 1'b0;
        tx_start      = 1'b1;
        tx_sel        = 6'd0;
        state_next    = SEND;
      end
      SEND: begin
        busy = 1'b1;
        if (tx_done) begin
          gap_cnt_next = 1'b0;
          if (byte_cnt_reg == LAST_BYTE) begin
            state_next = DONE;
          end else begin
            checksum_next = checksum_reg ^ cur_byte;
            state_next    = GAP;
          end
        end
      end
      GAP: begin
        busy = 1'b1;
        if (!gap_cnt_reg) begin
          gap_cnt_next = 1'b1;
        end else begin
          tx_start      = 1'b1;
          tx_sel        = byte_cnt_reg + 6'd1;
          byte_cnt_next = byte_cnt_reg + 6'd1;
          state_next    = SEND;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign tx_data  = packet_byte(tx_sel);
  assign cur_byte = packet_byte(byte_cnt_reg);
  assign state    = state_reg;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_line  (TxD),
    .tx_done  (tx_done)
  );

endmodule
